dmem_host_arbiter: RTL and testbench
====================================

// Module: dmem_host_arbiter
// PURPOSE
//  Shares the single-port data memory between the risc16b core data port and a host/debug
//  port (loader, monitor). The core cannot stall, so it always has absolute priority. Host
//  accesses use the idle memory cycles, with a req/ack handshake and a starvation watchdog.
//  Sits between risc16b d_* pins and the data SRAM (asynchronous read, synchronous write).
// PARAMETERS
//  AW        16  byte-address width (core and host)
//  DW        16  data width; byte lanes = DW/8 = 2
//  MAX_WAIT  15  host wait cycles before h_timeout sets; counter width $clog2(MAX_WAIT+1)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   reset, asynchronous, active-low
//  c_addr     in   AW  core d_addr
//  c_oe       in   1   core d_oe (read: lw/lbu)
//  c_we       in   2   core d_we byte enables (11 word, 01 even/upper lane, 10 odd/lower lane)
//  c_dout     in   DW  core write data
//  c_din      out  DW  read data to core d_din (combinational)
//  h_req      in   1   host request; level, held until h_ack
//  h_addr     in   AW  host byte address
//  h_we       in   2   host byte enables, same encoding as c_we; 00 = read
//  h_wdata    in   DW  host write data
//  h_ack      out  1   one-cycle completion pulse
//  h_rdata    out  DW  host read data; valid from h_ack, held until next completion
//  h_busy     out  1   host request accepted, not yet completed
//  h_timeout  out  1   sticky: host waited MAX_WAIT cycles
//  h_clr      in   1   clears h_timeout
//  m_addr     out  AW  memory byte address
//  m_oe       out  1   memory read enable
//  m_we       out  2   memory byte write enables
//  m_wdata    out  DW  memory write data
//  m_rdata    in   DW  memory read data (asynchronous)
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state IDLE; h_ack, h_busy, h_timeout = 0; h_rdata = 0;
//    wait counter = 0; captured host request registers = 0.
//  - core_acc = c_oe | (|c_we). If core_acc, m_* carry c_* exactly in the same cycle.
//    The core never waits. c_din = m_rdata at all times.
//  - FSM states are IDLE, WAIT, and ACK.
//    IDLE: if h_req = 1, capture h_addr, h_we and h_wdata, go to WAIT, h_busy = 1.
//          Host inputs are ignored after capture.
//    WAIT: if !core_acc, drive m_addr, m_we and m_wdata from the captured registers.
//          Drive m_oe = (captured we == 00), register m_rdata into h_rdata on reads, go to ACK.
//          If core_acc, wait counter +1 (saturating). When the counter reaches MAX_WAIT,
//          h_timeout is set.
//    ACK:  h_ack = 1 and h_busy = 0 for exactly one cycle. Clear the wait counter, go to IDLE.
//  - Host writes leave h_rdata unchanged.
//  - h_req still high in IDLE after ACK is a new request (back-to-back; minimum 3 cycles each).
//  - Neither core nor host active: m_oe = 0, m_we = 00, m_addr = c_addr, m_wdata = 0.
//  - h_timeout is set by the watchdog and cleared by h_clr. If both happen in the same
//    cycle, set wins. Timeout does not abort the pending request.
//  - Byte lanes pass through unmodified. m_addr stays a byte address; the memory uses
//    addr[AW-1:1].
//  - No combinational path from h_* inputs to h_ack.
// STRUCTURE
//  - Package risc16_mem_pkg:
//    - WE_NONE = 2'b00, WE_EVEN = 2'b01, WE_ODD = 2'b10, WE_WORD = 2'b11
//    - typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_ACK} arb_state_t
//  - Single module with no sub-module. Contents: FSM, capture registers, saturating wait
//    counter, and combinational memory mux.
// TESTING
//  1. Idle core: host write 0x00A0 <- 0xBEEF, we = 11, req at t0.
//     -> m_we = 11 at t1, h_ack at t2, memory word = 0xBEEF.
//  2. Host read 0x00A0 with the core idle.
//     -> h_rdata = 0xBEEF at h_ack, m_oe = 1 for exactly one cycle.
//  3. Core lw every cycle for 5 cycles during a host request.
//     -> m_* follow the core, c_din correct, host served in the first free cycle,
//        h_ack 1 cycle later.
//  4. Core busy for 20 cycles, MAX_WAIT = 15.
//     -> h_timeout = 1 after 15 wait cycles, request still completes.
//     -> h_clr then clears h_timeout; h_clr and set in the same cycle keeps it set.
//  5. Host sbu-style write we = 01 to 0x0010, data 0x5A00, with the core idle.
//     -> m_we = 01, only the upper byte changes.
//  6. rst low while in WAIT.
//     -> outputs 0 immediately (asynchronous), state IDLE.
//     -> after release, a new h_req is served normally.

Source files
------------

// File: rtl/risc16_mem_pkg.sv
// risc16_mem_pkg: shared byte-enable encodings and arbiter state type for the data memory path.
package risc16_mem_pkg;
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_EVEN = 2'b01;
  localparam logic [1:0] WE_ODD  = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_ACK} arb_state_t;
endpackage

// File: rtl/dmem_host_arbiter.sv
// dmem_host_arbiter: shares the data SRAM between the never-stalling core and a host port.
module dmem_host_arbiter
  import risc16_mem_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   c_addr,
  input  logic            c_oe,
  input  logic [DW/8-1:0] c_we,
  input  logic [DW-1:0]   c_dout,
  output logic [DW-1:0]   c_din,
  input  logic            h_req,
  input  logic [AW-1:0]   h_addr,
  input  logic [DW/8-1:0] h_we,
  input  logic [DW-1:0]   h_wdata,
  output logic            h_ack,
  output logic [DW-1:0]   h_rdata,
  output logic            h_busy,
  output logic            h_timeout,
  input  logic            h_clr,
  output logic [AW-1:0]   m_addr,
  output logic            m_oe,
  output logic [DW/8-1:0] m_we,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  arb_state_t r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic [DW/8-1:0] r_we;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;
  logic            w_core, w_grant, w_set;
  assign w_core  = c_oe | (|c_we);
  assign w_grant = (r_state == ARB_WAIT) && !w_core;
  // Watchdog keeps re-asserting while the host is still being starved, so it beats h_clr.
  assign w_set   = (r_state == ARB_WAIT) && w_core && (r_cnt >= CW'(MAX_WAIT - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_next;
  always_comb begin
    w_next = (r_state == ARB_IDLE) ? (h_req ? ARB_WAIT : ARB_IDLE) :
             (r_state == ARB_WAIT) ? (w_core ? ARB_WAIT : ARB_ACK) : ARB_IDLE;
  end
  always_comb begin
    m_addr  = w_grant ? r_addr : c_addr;
    m_oe    = w_core ? c_oe : (w_grant && (r_we == '0));
    m_we    = w_core ? c_we : (w_grant ? r_we : '0);
    m_wdata = w_core ? c_dout : (w_grant ? r_wdata : '0);
    h_ack   = (r_state == ARB_ACK);
    h_busy  = (r_state == ARB_WAIT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_addr    <= '0;
      r_we      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE && h_req) begin
        r_addr  <= h_addr;
        r_we    <= h_we;
        r_wdata <= h_wdata;
      end
      if (w_grant && r_we == '0) r_rdata <= m_rdata;
      if (r_state == ARB_ACK) r_cnt <= '0;
      else if (r_state == ARB_WAIT && w_core && r_cnt != CW'(MAX_WAIT)) r_cnt <= r_cnt + 1'b1;
      if (w_set) r_timeout <= 1'b1;
      else if (h_clr) r_timeout <= 1'b0;
    end
  assign c_din     = m_rdata;
  assign h_rdata   = r_rdata;
  assign h_timeout = r_timeout;
endmodule

// File: tb/tb_dmem_host_arbiter.sv
// tb_dmem_host_arbiter: directed vectors and corner sequences against a byte-lane SRAM model.
module tb_dmem_host_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] c_addr, c_dout, c_din, h_addr, h_wdata, h_rdata, m_addr, m_wdata, m_rdata;
  logic        c_oe, h_req, h_ack, h_busy, h_timeout, h_clr, m_oe;
  logic [1:0]  c_we, h_we, m_we;
  logic [15:0] mem [0:255];
  logic        loaded = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  dmem_host_arbiter dut (
    .clk(clk), .rst(rst),
    .c_addr(c_addr), .c_oe(c_oe), .c_we(c_we), .c_dout(c_dout), .c_din(c_din),
    .h_req(h_req), .h_addr(h_addr), .h_we(h_we), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata), .h_busy(h_busy), .h_timeout(h_timeout), .h_clr(h_clr),
    .m_addr(m_addr), .m_oe(m_oe), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Word i preloads to {i, ~i}; we[0] writes the upper (even) byte, we[1] the lower (odd) byte.
  assign m_rdata = mem[m_addr[8:1]];
  always @(posedge clk)
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= {8'(i), ~8'(i)};
      loaded <= 1'b1;
    end else begin
      if (m_we[0]) mem[m_addr[8:1]][15:8] <= m_wdata[15:8];
      if (m_we[1]) mem[m_addr[8:1]][7:0]  <= m_wdata[7:0];
    end

  typedef struct {
    logic [15:0] addr;
    logic        oe;
    logic [1:0]  we;
    logic [15:0] dout;
    logic [15:0] e_addr;
    logic        e_oe;
    logic [1:0]  e_we;
    logic [15:0] e_wdata;
    logic [15:0] e_din;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b0; c_addr = '0; c_oe = 1'b0; c_we = '0; c_dout = '0;
    h_req = 1'b0; h_addr = '0; h_we = '0; h_wdata = '0; h_clr = 1'b0;
    tv[0] = '{16'h1234, 1'b0, 2'b00, 16'hFFFF, 16'h1234, 1'b0, 2'b00, 16'h0000, 16'h1AE5};
    tv[1] = '{16'h0002, 1'b1, 2'b00, 16'h0000, 16'h0002, 1'b1, 2'b00, 16'h0000, 16'h01FE};
    tv[2] = '{16'h0004, 1'b0, 2'b11, 16'hCAFE, 16'h0004, 1'b0, 2'b11, 16'hCAFE, 16'h02FD};
    tv[3] = '{16'h0004, 1'b1, 2'b00, 16'h0000, 16'h0004, 1'b1, 2'b00, 16'h0000, 16'hCAFE};
    tv[4] = '{16'h0006, 1'b0, 2'b10, 16'h1122, 16'h0006, 1'b0, 2'b10, 16'h1122, 16'h03FC};
    tv[5] = '{16'h0006, 1'b1, 2'b00, 16'h0000, 16'h0006, 1'b1, 2'b00, 16'h0000, 16'h0322};
    tv[6] = '{16'h0006, 1'b0, 2'b01, 16'hAB00, 16'h0006, 1'b0, 2'b01, 16'hAB00, 16'h0322};
    tv[7] = '{16'h0007, 1'b1, 2'b00, 16'h0000, 16'h0007, 1'b1, 2'b00, 16'h0000, 16'hAB22};

    @(negedge clk); #1;
    chk("rst_ack", h_ack, 0); chk("rst_busy", h_busy, 0);
    chk("rst_timeout", h_timeout, 0); chk("rst_rdata", h_rdata, 0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_addr = tv[i].addr; c_oe = tv[i].oe; c_we = tv[i].we; c_dout = tv[i].dout;
      #1;
      chk($sformatf("vec%0d_m_addr", i), m_addr, tv[i].e_addr);
      chk($sformatf("vec%0d_m_oe", i), m_oe, tv[i].e_oe);
      chk($sformatf("vec%0d_m_we", i), m_we, tv[i].e_we);
      chk($sformatf("vec%0d_m_wdata", i), m_wdata, tv[i].e_wdata);
      chk($sformatf("vec%0d_c_din", i), c_din, tv[i].e_din);
    end
    @(negedge clk); c_oe = 1'b0; c_we = '0; c_dout = '0; c_addr = '0;

    // host word write, core idle
    @(negedge clk); h_req = 1'b1; h_addr = 16'h00A0; h_we = 2'b11; h_wdata = 16'hBEEF; #1;
    chk("w_t0_busy", h_busy, 0);
    @(negedge clk); #1;
    chk("w_t1_m_we", m_we, 2'b11); chk("w_t1_m_addr", m_addr, 16'h00A0);
    chk("w_t1_m_wdata", m_wdata, 16'hBEEF); chk("w_t1_busy", h_busy, 1);
    @(negedge clk); h_req = 1'b0; #1;
    chk("w_t2_ack", h_ack, 1); chk("w_t2_busy", h_busy, 0); chk("w_mem", mem[8'h50], 16'hBEEF);
    @(negedge clk); #1;
    chk("w_t3_ack", h_ack, 0);

    // host read back
    @(negedge clk); h_req = 1'b1; h_we = 2'b00; #1;
    @(negedge clk); #1;
    chk("r_m_oe", m_oe, 1); chk("r_m_addr", m_addr, 16'h00A0);
    @(negedge clk); h_req = 1'b0; #1;
    chk("r_ack", h_ack, 1); chk("r_rdata", h_rdata, 16'hBEEF); chk("r_m_oe_off", m_oe, 0);
    @(negedge clk); #1;
    chk("r_m_oe_once", m_oe, 0); chk("r_rdata_hold", h_rdata, 16'hBEEF);

    // core lw for 5 cycles while host waits
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin h_req = 1'b1; h_addr = 16'h0060; h_we = 2'b00; end
      c_oe = 1'b1; c_addr = 16'h0020 + 16'(2 * i); #1;
      b = 8'h10 + 8'(i);
      chk($sformatf("lw%0d_m_addr", i), m_addr, 16'h0020 + 16'(2 * i));
      chk($sformatf("lw%0d_c_din", i), c_din, {b, ~b});
      chk($sformatf("lw%0d_ack", i), h_ack, 0);
    end
    @(negedge clk); c_oe = 1'b0; #1;
    chk("lw_host_addr", m_addr, 16'h0060); chk("lw_host_oe", m_oe, 1); chk("lw_busy", h_busy, 1);
    @(negedge clk); h_req = 1'b0; #1;
    chk("lw_ack", h_ack, 1); chk("lw_rdata", h_rdata, 16'h30CF); chk("lw_no_timeout", h_timeout, 0);

    // core busy for 20 cycles: watchdog, set-over-clear, then clear
    @(negedge clk); h_req = 1'b1; h_addr = 16'h0030; h_we = 2'b00; c_oe = 1'b1; c_addr = 16'h0100;
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      if (n == 17) h_clr = 1'b1;
      if (n == 18) h_clr = 1'b0;
      #1;
      if (n == 15) chk("to_before", h_timeout, 0);
      if (n == 16) chk("to_set", h_timeout, 1);
      if (n == 18) chk("to_set_wins", h_timeout, 1);
      if (n == 19) chk("to_still_busy", h_busy, 1);
    end
    @(negedge clk); c_oe = 1'b0; #1;
    chk("to_grant_addr", m_addr, 16'h0030); chk("to_grant_oe", m_oe, 1);
    @(negedge clk); h_req = 1'b0; h_clr = 1'b1; #1;
    chk("to_ack", h_ack, 1); chk("to_rdata", h_rdata, 16'h18E7); chk("to_sticky", h_timeout, 1);
    @(negedge clk); h_clr = 1'b0; #1;
    chk("to_cleared", h_timeout, 0);

    // host even-lane write
    @(negedge clk); h_req = 1'b1; h_addr = 16'h0010; h_we = 2'b01; h_wdata = 16'h5A00; #1;
    @(negedge clk); #1;
    chk("sb_m_we", m_we, 2'b01); chk("sb_m_wdata", m_wdata, 16'h5A00);
    @(negedge clk); h_req = 1'b0; #1;
    chk("sb_ack", h_ack, 1); chk("sb_mem", mem[8'h08], 16'h5AF7); chk("sb_rdata_kept", h_rdata, 16'h18E7);

    // asynchronous reset while waiting
    @(negedge clk); h_req = 1'b1; h_addr = 16'h0040; h_we = 2'b00; c_oe = 1'b1; c_addr = 16'h0002;
    @(negedge clk); #1;
    chk("ar_busy_pre", h_busy, 1);
    #1; rst = 1'b0; c_oe = 1'b0; h_req = 1'b0; #1;
    chk("ar_busy", h_busy, 0); chk("ar_ack", h_ack, 0); chk("ar_rdata", h_rdata, 0);
    chk("ar_m_oe", m_oe, 0); chk("ar_m_addr", m_addr, 16'h0002);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); h_req = 1'b1; #1;
    @(negedge clk); #1;
    chk("ar_new_oe", m_oe, 1); chk("ar_new_addr", m_addr, 16'h0040);
    @(negedge clk); h_req = 1'b0; #1;
    chk("ar_new_ack", h_ack, 1); chk("ar_new_rdata", h_rdata, 16'h20DF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
